// File: rtl/instr_encode_loader.sv
// instr_encode_loader: encodes RV32I field bundles into machine words and
// writes them to consecutive instruction-memory addresses per load session.
module instr_encode_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic              funct7_5,
  input  logic [12:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  state_t state_q, state_d;
  logic [ADDR_W:0] count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, enc;
  logic err_q, err_d, we_q, we_d, legal, hs, imm_ok, shift;
  always_comb begin
    imm_ok = imm[12] == imm[11];
    shift  = funct3 == 3'b001 || funct3 == 3'b101;
    legal  = fmt == 3'd0 ? 1'b1
           : (fmt >= 3'd1 && fmt <= 3'd3) ? imm_ok
           : fmt == 3'd4 ? ~imm[0] : 1'b0;
    // Shift-immediates carry funct7 in the upper immediate bits and shamt below.
    enc = fmt == 3'd0 ? {1'b0, funct7_5, 5'b0, rs2, rs1, funct3, rd, 7'b0110011}
        : fmt == 3'd1 ? {shift ? {1'b0, funct7_5, 5'b0, imm[4:0]} : imm[11:0], rs1, funct3, rd, 7'b0010011}
        : fmt == 3'd2 ? {imm[11:0], rs1, 3'b010, rd, 7'b0000011}
        : fmt == 3'd3 ? {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011}
        : fmt == 3'd4 ? {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011}
        : 32'h0;
    in_ready = state_q == RUN && count_q < DEPTH_C;
    hs       = in_valid && in_ready;
  end
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (state_q != RUN && start) begin
      state_d = RUN;
      count_d = '0;
      err_d   = 1'b0;
    end else if (state_q == RUN) begin
      if (hs && legal) begin
        we_d    = 1'b1;
        addr_d  = count_q[ADDR_W-1:0];
        wdata_d = enc;
        count_d = count_q + 1'b1;
      end
      if (hs && !legal) err_d = 1'b1;
      if (finish) state_d = DONE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign full       = count_q == DEPTH_C;
  assign err        = err_q;
  assign done       = state_q == DONE;
endmodule
